// File: rtl/sdr_wb_arbiter.sv
// rtl/sdr_wb_arbiter.sv - round-robin Wishbone arbiter sharing the SDRAM controller slave port
// Grant is held for a master's whole cyc; a stall watchdog aborts hung cycles with an err pulse.
module sdr_wb_arbiter #(
  parameter int NUM_M   = 4,
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int SELW    = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   sys_clk,
  input  logic                   RESETN,
  input  logic [NUM_M-1:0]       m_cyc,
  input  logic [NUM_M-1:0]       m_stb,
  input  logic [NUM_M-1:0]       m_we,
  input  logic [NUM_M*AW-1:0]    m_addr,
  input  logic [NUM_M*SELW-1:0]  m_sel,
  input  logic [NUM_M*DW-1:0]    m_dat_i,
  input  logic [NUM_M*3-1:0]     m_cti,
  output logic [DW-1:0]          m_dat_o,
  output logic [NUM_M-1:0]       m_ack,
  output logic [NUM_M-1:0]       m_err,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [AW-1:0]          s_addr,
  output logic [SELW-1:0]        s_sel,
  output logic [DW-1:0]          s_dat_o,
  output logic [2:0]             s_cti,
  input  logic [DW-1:0]          s_dat_i,
  input  logic                   s_ack,
  output logic [NUM_M-1:0]       grant,
  output logic [7:0]             timeout_cnt
);
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t            state;
  logic [IW-1:0]     last_owner;
  logic [15:0]       watchdog;

  logic [IW:0]       cand;
  logic [IW-1:0]     winner;
  logic [NUM_M-1:0]  winner_oh;
  logic              own;
  logic              g_cyc;
  logic              g_stb;
  logic              g_we;
  logic [AW-1:0]     g_addr;
  logic [SELW-1:0]   g_sel;
  logic [DW-1:0]     g_dat;
  logic [2:0]        g_cti;

  // Scan downward so the requester closest after last_owner is the final assignment.
  always_comb begin
    winner = last_owner;
    cand   = '0;
    for (int k = NUM_M; k >= 1; k--) begin
      cand = {1'b0, last_owner} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_M)) begin
        cand = cand - (IW+1)'(NUM_M);
      end
      if (m_cyc[cand[IW-1:0]]) begin
        winner = cand[IW-1:0];
      end
    end
    winner_oh         = '0;
    winner_oh[winner] = 1'b1;
  end

  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_sel  = '0;
    g_dat  = '0;
    g_cti  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant[i]) begin
        g_cyc  = g_cyc  | m_cyc[i];
        g_stb  = g_stb  | m_stb[i];
        g_we   = g_we   | m_we[i];
        g_addr = g_addr | m_addr[i*AW +: AW];
        g_sel  = g_sel  | m_sel[i*SELW +: SELW];
        g_dat  = g_dat  | m_dat_i[i*DW +: DW];
        g_cti  = g_cti  | m_cti[i*3 +: 3];
      end
    end
  end

  assign own     = (state == OWN);
  assign s_cyc   = own & g_cyc;
  assign s_stb   = own & g_cyc & g_stb;
  assign s_we    = g_we;
  assign s_addr  = g_addr;
  assign s_sel   = g_sel;
  assign s_dat_o = g_dat;
  assign s_cti   = g_cti;
  assign m_dat_o = s_dat_i;
  assign m_ack   = own ? (grant & {NUM_M{s_ack}}) : '0;
  assign m_err   = (state == ABORT) ? grant : '0;

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state       <= IDLE;
      grant       <= '0;
      last_owner  <= IW'(NUM_M - 1);
      watchdog    <= '0;
      timeout_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_cyc) begin
            grant      <= winner_oh;
            last_owner <= winner;
            state      <= OWN;
          end
        end
        OWN: begin
          if (!g_cyc) begin
            grant    <= '0;
            watchdog <= '0;
            state    <= IDLE;
          end else if (s_stb && !s_ack) begin
            if (watchdog == 16'(TIMEOUT - 1)) begin
              watchdog <= '0;
              state    <= ABORT;
            end else begin
              watchdog <= watchdog + 16'd1;
            end
          end else begin
            watchdog <= '0;
          end
        end
        ABORT: begin
          if (timeout_cnt != 8'hFF) begin
            timeout_cnt <= timeout_cnt + 8'd1;
          end
          grant <= '0;
          state <= IDLE;
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
// tb/tb_sdr_wb_arbiter.sv - scoreboard bench for sdr_wb_arbiter with a cycle-level reference model
// Directed scenarios followed by randomized master/slave traffic and a watchdog-saturation run.
module tb_sdr_wb_arbiter;
  localparam int NUM_M = 4;
  localparam int DW    = 32;
  localparam int AW    = 26;
  localparam int SELW  = 4;
  localparam int TO    = 16;

  logic                  sys_clk = 1'b0;
  logic                  RESETN  = 1'b0;
  logic [NUM_M-1:0]      m_cyc, m_stb, m_we;
  logic [NUM_M*AW-1:0]   m_addr;
  logic [NUM_M*SELW-1:0] m_sel;
  logic [NUM_M*DW-1:0]   m_dat_i;
  logic [NUM_M*3-1:0]    m_cti;
  logic [DW-1:0]         m_dat_o;
  logic [NUM_M-1:0]      m_ack, m_err;
  logic                  s_cyc, s_stb, s_we;
  logic [AW-1:0]         s_addr;
  logic [SELW-1:0]       s_sel;
  logic [DW-1:0]         s_dat_o;
  logic [2:0]            s_cti;
  logic [DW-1:0]         s_dat_i;
  logic                  s_ack;
  logic [NUM_M-1:0]      grant;
  logic [7:0]            timeout_cnt;

  always #5 sys_clk = ~sys_clk;

  sdr_wb_arbiter #(.NUM_M(NUM_M), .DW(DW), .AW(AW), .SELW(SELW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .RESETN(RESETN),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel),
    .m_dat_i(m_dat_i), .m_cti(m_cti), .m_dat_o(m_dat_o), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel),
    .s_dat_o(s_dat_o), .s_cti(s_cti), .s_dat_i(s_dat_i), .s_ack(s_ack),
    .grant(grant), .timeout_cnt(timeout_cnt)
  );

  typedef struct {
    logic [NUM_M-1:0] grant, m_ack, m_err;
    logic             s_cyc, s_stb, s_we;
    logic [AW-1:0]    s_addr;
    logic [SELW-1:0]  s_sel;
    logic [DW-1:0]    s_dat_o, m_dat_o;
    logic [2:0]       s_cti;
    logic [7:0]       tcnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: phase 0 idle, 1 owned by cur, 2 aborting cur
  int ph, cur, last, stall, tcnt;
  logic [NUM_M-1:0] prev_ack, prev_err;

  int mode = 0;
  bit stall_mode = 0;
  logic [NUM_M-1:0] req_mask = '0;
  int rem[NUM_M];
  logic [NUM_M-1:0] gseq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (RESETN) begin
        chk("grant", 64'(grant), 64'(mon_e.grant));
        chk("m_ack", 64'(m_ack), 64'(mon_e.m_ack));
        chk("m_err", 64'(m_err), 64'(mon_e.m_err));
        chk("s_cyc", 64'(s_cyc), 64'(mon_e.s_cyc));
        chk("s_stb", 64'(s_stb), 64'(mon_e.s_stb));
        chk("m_dat_o", 64'(m_dat_o), 64'(mon_e.m_dat_o));
        chk("timeout_cnt", 64'(timeout_cnt), 64'(mon_e.tcnt));
        if (mon_e.s_cyc) begin
          chk("s_we", 64'(s_we), 64'(mon_e.s_we));
          chk("s_addr", 64'(s_addr), 64'(mon_e.s_addr));
          chk("s_sel", 64'(s_sel), 64'(mon_e.s_sel));
          chk("s_dat_o", 64'(s_dat_o), 64'(mon_e.s_dat_o));
          chk("s_cti", 64'(s_cti), 64'(mon_e.s_cti));
        end
      end
    end
  end

  task automatic model_reset();
    ph = 0; cur = -1; last = NUM_M - 1; stall = 0; tcnt = 0;
    prev_ack = '0; prev_err = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!RESETN) begin
      model_reset();
      return;
    end
    case (ph)
      0: begin
        for (int k = 1; k <= NUM_M; k++) begin
          w = (last + k) % NUM_M;
          if (m_cyc[w]) begin
            cur = w; last = w; ph = 1;
            break;
          end
        end
      end
      1: begin
        if (!m_cyc[cur]) begin
          ph = 0; cur = -1; stall = 0;
        end else if (m_stb[cur] && !s_ack) begin
          stall++;
          if (stall == TO) begin
            ph = 2; stall = 0;
          end
        end else begin
          stall = 0;
        end
      end
      default: begin
        if (tcnt < 255) tcnt++;
        ph = 0; cur = -1;
      end
    endcase
  endtask

  task automatic model_push();
    exp_t e;
    e.grant = '0; e.m_ack = '0; e.m_err = '0;
    e.s_cyc = 1'b0; e.s_stb = 1'b0; e.s_we = 1'b0;
    e.s_addr = '0; e.s_sel = '0; e.s_dat_o = '0; e.s_cti = '0;
    if (cur >= 0) e.grant[cur] = 1'b1;
    if (ph == 1) begin
      e.m_ack[cur] = s_ack;
      if (m_cyc[cur]) begin
        e.s_cyc   = 1'b1;
        e.s_stb   = m_stb[cur];
        e.s_we    = m_we[cur];
        e.s_addr  = m_addr[cur*AW +: AW];
        e.s_sel   = m_sel[cur*SELW +: SELW];
        e.s_dat_o = m_dat_i[cur*DW +: DW];
        e.s_cti   = m_cti[cur*3 +: 3];
      end
    end
    if (ph == 2) e.m_err[cur] = 1'b1;
    e.m_dat_o = s_dat_i;
    e.tcnt    = 8'(tcnt);
    sbq.push_back(e);
    prev_ack = e.m_ack;
    prev_err = e.m_err;
  endtask

  task automatic agents();
    bit dropped;
    for (int i = 0; i < NUM_M; i++) begin
      dropped = 0;
      if (rem[i] > 0) begin
        if (prev_err[i] || (!stall_mode && $urandom_range(0, 59) == 0)) begin
          rem[i] = 0; dropped = 1;
        end else if (prev_ack[i]) begin
          rem[i]--;
          if (rem[i] == 0) dropped = 1;
          else begin
            m_addr[i*AW +: AW] = m_addr[i*AW +: AW] + AW'(4);
            m_dat_i[i*DW +: DW] = $urandom();
          end
        end
      end
      if (rem[i] == 0 && !dropped && $urandom_range(0, 3) == 0) begin
        rem[i] = $urandom_range(1, 8);
        m_we[i] = 1'($urandom_range(0, 1));
        m_addr[i*AW +: AW] = AW'($urandom());
        m_sel[i*SELW +: SELW] = SELW'($urandom());
        m_dat_i[i*DW +: DW] = $urandom();
      end
      m_cyc[i] = (rem[i] > 0);
      m_stb[i] = (rem[i] > 0) && (stall_mode || $urandom_range(0, 4) != 0);
      m_cti[i*3 +: 3] = (rem[i] == 1) ? 3'b111 : 3'b010;
    end
    s_ack = stall_mode ? 1'b0 : ($urandom_range(0, 9) < 6);
    s_dat_i = $urandom();
  endtask

  task automatic one_beat();
    for (int i = 0; i < NUM_M; i++) begin
      if (req_mask[i]) begin
        m_cyc[i] = !(prev_ack[i] && m_cyc[i]);
        m_stb[i] = m_cyc[i];
        m_cti[i*3 +: 3] = 3'b111;
      end
    end
    s_ack = 1'b1;
  endtask

  task automatic cyc_begin();
    @(posedge sys_clk);
    model_edge();
    #1;
    if (mode == 1) agents();
    else if (mode == 2) one_beat();
  endtask

  task automatic cyc_end();
    model_push();
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_sel = '0;
    m_dat_i = '0; m_cti = '0; s_ack = 1'b0; s_dat_i = '0;
    for (int i = 0; i < NUM_M; i++) rem[i] = 0;
    mode = 0; stall_mode = 0; req_mask = '0;
  endtask

  task automatic do_reset();
    #2;
    RESETN = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge sys_clk);
    #1;
    RESETN = 1'b1;
  endtask

  task automatic set_m(input int i, input logic cyc, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] cti);
    m_cyc[i] = cyc; m_stb[i] = cyc; m_we[i] = we;
    m_addr[i*AW +: AW] = a; m_dat_i[i*DW +: DW] = d;
    m_sel[i*SELW +: SELW] = '1; m_cti[i*3 +: 3] = cti;
  endtask

  task automatic run_collect(input int n);
    logic [NUM_M-1:0] pg;
    pg = '0;
    gseq.delete();
    repeat (n) begin
      tick();
      #1;
      if (grant != 0 && pg == 0) gseq.push_back(grant);
      pg = grant;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: simulation exceeded time budget");
    $fatal(1, "time budget exceeded");
  end

  initial begin
    int acks, k, errk, errn;
    bit held, seen0, regrant;
    logic [NUM_M-1:0] got, errv, g1;
    logic errcyc;
    logic [7:0] tc1;

    clear_inputs();
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_m_ack", 64'(m_ack), 64'd0);
    chk("rst_m_err", 64'(m_err), 64'd0);
    chk("rst_tcnt", 64'(timeout_cnt), 64'd0);
    RESETN = 1'b1;

    // master 1 write then read in one Wishbone cycle
    cyc_begin(); set_m(1, 1'b1, 1'b1, 26'h0000100, 32'hDEADBEEF, 3'b111); cyc_end();
    cyc_begin(); s_ack = 1'b1; cyc_end();
    #1;
    chk("wr_grant", 64'(grant), 64'b0010);
    chk("wr_addr", 64'(s_addr), 64'h100);
    chk("wr_ack", 64'(m_ack), 64'b0010);
    chk("wr_data", 64'(s_dat_o), 64'hDEADBEEF);
    cyc_begin(); m_we[1] = 1'b0; s_dat_i = 32'hDEADBEEF; s_ack = 1'b1; cyc_end();
    #1;
    chk("rd_data", 64'(m_dat_o), 64'hDEADBEEF);
    chk("rd_ack", 64'(m_ack), 64'b0010);
    cyc_begin(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0; cyc_end();
    tick();

    // masters 0 and 2 together after reset
    do_reset();
    mode = 2; req_mask = 4'b0101;
    run_collect(8);
    chk("pair_count", 64'(gseq.size() >= 2), 64'd1);
    if (gseq.size() >= 2) begin
      chk("pair_first", 64'(gseq[0]), 64'b0001);
      chk("pair_second", 64'(gseq[1]), 64'b0100);
    end

    // all four masters, one-beat cycles
    do_reset();
    mode = 2; req_mask = 4'b1111;
    run_collect(18);
    chk("rr_count", 64'(gseq.size() >= 5), 64'd1);
    for (int i = 0; i < 5 && i < gseq.size(); i++)
      chk($sformatf("rr_seq%0d", i), 64'(gseq[i]), 64'(4'b0001 << (i % 4)));

    // 8-beat burst from master 3 while master 0 waits
    do_reset();
    cyc_begin(); set_m(3, 1'b1, 1'b1, 26'h200, 32'h33330000, 3'b010); s_ack = 1'b1; cyc_end();
    acks = 0; held = 1;
    for (int c = 0; c < 30 && acks < 8; c++) begin
      cyc_begin();
      m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      m_addr[3*AW +: AW] = AW'(32'h200 + acks * 4);
      m_cti[3*3 +: 3] = (acks == 7) ? 3'b111 : 3'b010;
      s_ack = 1'b1;
      cyc_end();
      #1;
      if (m_ack[3]) begin
        acks++;
        if (grant !== 4'b1000) held = 0;
      end
    end
    chk("burst_acks", 64'(acks), 64'd8);
    chk("burst_held", 64'(held), 64'd1);
    cyc_begin(); m_cyc[3] = 1'b0; m_stb[3] = 1'b0; cyc_end();
    seen0 = 0; got = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      if (grant == 0) seen0 = 1;
      else if (seen0 && got == 0) got = grant;
    end
    chk("burst_next", 64'(got), 64'b0001);

    // watchdog abort on master 1
    do_reset();
    cyc_begin(); set_m(1, 1'b1, 1'b0, 26'h40, 32'h0, 3'b000); s_ack = 1'b0; cyc_end();
    k = -1; errk = -1; errn = 0; regrant = 0; errv = '0; errcyc = 1'b1; tc1 = '0; g1 = '1;
    for (int c = 0; c < 30; c++) begin
      tick();
      #1;
      if (k < 0 && grant == 4'b0010) k = 0;
      else if (k >= 0) k++;
      if (m_err != 0) begin
        errn++;
        if (errk < 0) begin errk = k; errv = m_err; errcyc = s_cyc; end
      end
      if (errk >= 0 && k == errk + 1) begin tc1 = timeout_cnt; g1 = grant; end
      if (errk >= 0 && k > errk + 1 && grant == 4'b0010) regrant = 1;
    end
    chk("wd_cycle", 64'(errk), 64'(TO));
    chk("wd_err", 64'(errv), 64'b0010);
    chk("wd_pulses", 64'(errn), 64'd1);
    chk("wd_s_cyc", 64'(errcyc), 64'd0);
    chk("wd_tcnt", 64'(tc1), 64'd1);
    chk("wd_idle", 64'(g1), 64'd0);
    chk("wd_regrant", 64'(regrant), 64'd1);
    cyc_begin(); m_cyc[1] = 1'b0; m_stb[1] = 1'b0; cyc_end();

    // asynchronous reset mid-burst on master 2
    do_reset();
    cyc_begin(); set_m(2, 1'b1, 1'b1, 26'h300, 32'h22222222, 3'b010); s_ack = 1'b1; cyc_end();
    tick();
    tick();
    #2;
    RESETN = 1'b0;
    #1;
    chk("arst_grant", 64'(grant), 64'd0);
    chk("arst_s_cyc", 64'(s_cyc), 64'd0);
    chk("arst_m_err", 64'(m_err), 64'd0);
    clear_inputs();
    model_reset();
    @(posedge sys_clk);
    #1;
    RESETN = 1'b1;
    cyc_begin(); set_m(0, 1'b1, 1'b0, 26'h0, 32'h0, 3'b000); set_m(2, 1'b1, 1'b0, 26'h8, 32'h0, 3'b000); cyc_end();
    tick();
    #1;
    chk("arst_prio", 64'(grant), 64'b0001);
    cyc_begin(); m_cyc = '0; m_stb = '0; cyc_end();

    // randomized traffic, a stall window, then saturate the abort counter
    do_reset();
    mode = 1;
    repeat (1500) tick();
    stall_mode = 1;
    repeat (120) tick();
    stall_mode = 0;
    repeat (800) tick();
    stall_mode = 1;
    repeat (6000) tick();
    #1;
    chk("tcnt_sat", 64'(timeout_cnt), 64'd255);
    stall_mode = 0;
    repeat (3) tick();
    @(negedge sys_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdr_wb_arbiter.md
Name: sdr_wb_arbiter

Overview:
Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller among NUM_M bus masters. Sits between the masters (CPU, DMA, test agents) and the controller's wishbone interface, in the sys_clk domain. Holds a grant for a master's whole cycle (cyc high), so multi-beat bursts are never interleaved. Provides a stall watchdog that aborts a hung cycle with an error pulse.

Parameters:
NUM_M, 4, number of masters (2..8)
DW, 32, Wishbone data width
AW, 26, Wishbone byte address width
SELW, DW/8, byte-select width
TIMEOUT, 255, max cycles stb may wait for ack before abort (1..65535)

Ports:
sys_clk  in  1  system/Wishbone clock
RESETN  in  1  asynchronous active-low reset
m_cyc  in  NUM_M  per-master cycle request
m_stb  in  NUM_M  per-master strobe
m_we  in  NUM_M  per-master write enable
m_addr  in  NUM_M*AW  per-master address, master i at [i*AW +: AW]
m_sel  in  NUM_M*SELW  per-master byte selects
m_dat_i  in  NUM_M*DW  per-master write data
m_cti  in  NUM_M*3  per-master cycle type identifier
m_dat_o  out  DW  read data, broadcast to all masters
m_ack  out  NUM_M  per-master acknowledge
m_err  out  NUM_M  per-master error (watchdog abort)
s_cyc  out  1  to controller: cycle
s_stb  out  1  to controller: strobe
s_we  out  1  to controller: write enable
s_addr  out  AW  to controller: address
s_sel  out  SELW  to controller: byte selects
s_dat_o  out  DW  to controller: write data
s_cti  out  3  to controller: cycle type
s_dat_i  in  DW  from controller: read data
s_ack  in  1  from controller: acknowledge
grant  out  NUM_M  one-hot current owner, 0 when idle
timeout_cnt  out  8  saturating count of watchdog aborts

Behaviour:
- Reset (RESETN low, async): state=IDLE, grant=0, last_owner=NUM_M-1 (master 0 wins first), watchdog=0, timeout_cnt=0, m_err=0. s_cyc, s_stb, m_ack are 0 because grant=0.
- FSM states: IDLE, OWN, ABORT.
- IDLE: if any m_cyc bit is set, select the first requester searching from last_owner+1 upward, mod NUM_M. Register grant one-hot, last_owner=winner, go to OWN. Latency: m_cyc seen at edge N gives s_cyc high in cycle N+1.
- OWN: s_cyc, s_stb, s_we, s_addr, s_sel, s_dat_o and s_cti are combinationally muxed from the granted master, with stb gated by that master's cyc. m_ack[g]=s_ack; all other m_ack bits are 0. m_dat_o=s_dat_i at all times.
- OWN exit: when the granted m_cyc is low at a clock edge, clear grant and go to IDLE. This inserts exactly one idle cycle (s_cyc=0) between owners, even if the same or another master is requesting. Other masters' requests never preempt the owner, regardless of m_cti.
- Watchdog: the counter increments each cycle in OWN with s_stb=1 and s_ack=0. It clears on s_ack, on s_stb=0, or on leaving OWN. When the counter reaches TIMEOUT, go to ABORT.
- ABORT (1 cycle): s_cyc=s_stb=0, m_err[g]=1 for exactly this cycle, m_ack=0. timeout_cnt increments and saturates at 255. Clear grant, go to IDLE. s_ack arriving during ABORT is dropped.
- Non-granted masters see ack=0 and err=0 and simply wait. No request is lost as long as the master holds cyc.
- Simultaneous requests resolve in the same cycle by rotation. Over a full rotation, every persistent requester is granted once before any master is granted twice.
- Only grant, state, last_owner, watchdog and timeout_cnt are registered. The datapath adds no latency: ack-to-master is combinational from s_ack.
- A master deasserting cyc mid-burst ends ownership at that edge, and the arbiter does not wait for outstanding acks. The controller must tolerate cyc drop, per the Wishbone rule.

Test Plan:
- Single master 1 writes 0xDEADBEEF to 0x0000100, then reads it back: grant=0010 one cycle after m_cyc[1]; s_addr=0x0000100; m_ack[1] follows s_ack; m_dat_o=0xDEADBEEF; m_ack[0,2,3]=0 throughout.
- Masters 0 and 2 both raise cyc in the same cycle after reset: master 0 is granted first; after it drops cyc, one cycle of s_cyc=0, then grant=0100.
- All four masters request continuously, each doing 1-beat cycles: the grant sequence is 0001, 0010, 0100, 1000, 0001, each separated by one idle cycle.
- Master 3 issues an 8-beat incrementing burst (cti=010, last beat 111) while master 0 requests: grant stays 1000 for all 8 acks; master 0 is granted only after master 3 drops cyc.
- With TIMEOUT=16, tie s_ack=0 while master 1 strobes: after 16 cycles, m_err[1] pulses for one cycle, s_cyc goes to 0, timeout_cnt=1, the FSM returns to IDLE, and the next request is granted normally.
- Assert RESETN low mid-burst while master 2 is granted: grant=0, s_cyc=0 and m_err=0 immediately, without waiting for a clock. After release, master 0 has priority again.
